pm_sort_ctrl: RTL and testbench



---
 rtl/pm_sort_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pm_sort_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_sort_ctrl.sv
// pm_sort_ctrl: sequential path-metric sorter controller for the SCL decoder.
//
// Buffers NUM {index, PM} entries, sorts them in place by odd-even
// transposition using a single compare-and-swap unit (one pair per cycle),
// then streams out the KEEP entries with the smallest path metrics.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort, returns to LOAD and drops the current job
//   in_valid   input entry valid
//   in_ready   high only while loading
//   in_data    candidate entry {index, PM}
//   out_valid  output entry valid
//   out_ready  downstream accept
//   out_data   sorted entry, zero when out_valid is low
//   out_last   marks the KEEP-th output entry
//   busy       high while sorting or emitting
module pm_sort_ctrl #(
    parameter int PM_WIDTH    = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int NUM         = 8,
    parameter int KEEP        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PM_WIDTH+INDEX_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PM_WIDTH+INDEX_WIDTH-1:0] out_data,
    output logic                            out_last,
    output logic                            busy
);

    localparam int EW = PM_WIDTH + INDEX_WIDTH;
    localparam int PW = $clog2(NUM);

    localparam logic [PW-1:0] LAST_SLOT = PW'(NUM - 1);
    localparam logic [PW-1:0] KEEP_LAST = PW'(KEEP - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]  pass_reg, pass_next;
    logic [PW-1:0]  pair_reg, pair_next;
    logic [EW-1:0]  bank_reg [NUM];

    logic           in_fire, out_fire;
    logic           last_load, last_out, last_pair, last_pass, sort_done;
    logic [PW-1:0]  pair_hi;
    logic [EW-1:0]  cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic           swap;

    // Handshakes are void in a cycle where clr is asserted.
    assign in_fire   = in_valid && (state_reg == S_LOAD) && !clr;
    assign out_fire  = out_ready && (state_reg == S_OUT) && !clr;
    assign last_load = in_fire && (wr_ptr_reg == LAST_SLOT);
    assign last_out  = out_fire && (rd_ptr_reg == KEEP_LAST);

    // The current pair (j, j+1) is the last of its pass when j+2 would run
    // off the end of the bank, i.e. j+3 >= NUM.
    assign last_pair = (int'(pair_reg) + 3 >= NUM);
    assign last_pass = (pass_reg == LAST_SLOT);
    assign sort_done = (state_reg == S_SORT) && last_pair && last_pass;

    // Compare-and-swap: strict less-than keeps the pair, equal PMs swap.
    assign pair_hi = pair_reg + PW'(1);
    assign cmp_a   = bank_reg[pair_reg];
    assign cmp_b   = bank_reg[pair_hi];
    assign swap    = !(cmp_a[PM_WIDTH-1:0] < cmp_b[PM_WIDTH-1:0]);
    assign cmp_lo  = swap ? cmp_b : cmp_a;
    assign cmp_hi  = swap ? cmp_a : cmp_b;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = S_LOAD;
        end else begin
            case (state_reg)
                S_LOAD:  if (last_load) state_next = S_SORT;
                S_SORT:  if (sort_done) state_next = S_OUT;
                S_OUT:   if (last_out)  state_next = S_LOAD;
                default: state_next = S_LOAD;
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (state_reg == S_LOAD);
        busy      = (state_reg == S_SORT) || (state_reg == S_OUT);
        out_valid = (state_reg == S_OUT);
        out_data  = '0;
        out_last  = 1'b0;
        if (state_reg == S_OUT) begin
            out_data = bank_reg[rd_ptr_reg];
            out_last = (rd_ptr_reg == KEEP_LAST);
        end
    end

    // Pointer and pass/pair sequencing
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        pass_next   = pass_reg;
        pair_next   = pair_reg;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            pass_next   = '0;
            pair_next   = '0;
        end else begin
            if (in_fire) begin
                wr_ptr_next = last_load ? '0 : wr_ptr_reg + PW'(1);
            end
            if (state_reg == S_SORT) begin
                if (last_pair) begin
                    // Next pass starts at j = (pass+1) % 2, no idle cycle.
                    pass_next = last_pass ? '0 : pass_reg + PW'(1);
                    pair_next = last_pass ? '0 : {{(PW-1){1'b0}}, ~pass_reg[0]};
                end else begin
                    pair_next = pair_reg + PW'(2);
                end
            end
            if (out_fire) begin
                rd_ptr_next = last_out ? '0 : rd_ptr_reg + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            pass_reg   <= '0;
            pair_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            pass_reg   <= pass_next;
            pair_reg   <= pair_next;
        end
    end

    // Entry bank: written by the loader in LOAD and by the compare-and-swap
    // unit in SORT; the two never overlap in time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM; i++) begin
                bank_reg[i] <= '0;
            end
        end else if (!clr) begin
            for (int i = 0; i < NUM; i++) begin
                if (in_fire && (wr_ptr_reg == PW'(i))) begin
                    bank_reg[i] <= in_data;
                end else if ((state_reg == S_SORT) && (pair_reg == PW'(i))) begin
                    bank_reg[i] <= cmp_lo;
                end else if ((state_reg == S_SORT) && (pair_hi == PW'(i))) begin
                    bank_reg[i] <= cmp_hi;
                end
            end
        end
    end

endmodule

// File: tb/tb_pm_sort_ctrl.sv
// Testbench for pm_sort_ctrl: table-driven sort jobs plus hand-written
// abort and mid-output reset sequences.
module tb_pm_sort_ctrl;

    localparam int PMW = 8;
    localparam int IW  = 3;
    localparam int N   = 8;
    localparam int K   = 4;
    localparam int EW  = PMW + IW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    pm_sort_ctrl #(
        .PM_WIDTH   (PMW),
        .INDEX_WIDTH(IW),
        .NUM        (N),
        .KEEP       (K)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][PMW-1:0] pm;
        logic [N-1:0][IW-1:0]  idx;
        logic [K-1:0][EW-1:0]  exp;
        logic                  bp;
        logic                  gaps;
    } vec_t;

    vec_t          tbl [4];
    logic [EW-1:0] model [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference odd-even transposition, swapping on equal PMs.
    task automatic model_sort();
        logic [EW-1:0] t;
        for (int p = 0; p < N; p++) begin
            for (int j = p % 2; j + 1 < N; j += 2) begin
                if (!(model[j][PMW-1:0] < model[j+1][PMW-1:0])) begin
                    t          = model[j];
                    model[j]   = model[j+1];
                    model[j+1] = t;
                end
            end
        end
    endtask

    // Returns at the first negedge after the accept edge of the last entry.
    task automatic load_job(input vec_t v);
        int i = 0;
        int guard = 0;
        while (i < N && guard < 400) begin
            @(negedge clk);
            guard++;
            if (v.gaps && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = {v.idx[i], v.pm[i]};
                if (in_ready) begin
                    $display("in  %0d: idx=%0d pm=%0d", i, v.idx[i], v.pm[i]);
                    i++;
                end
            end
        end
        if (i < N) check("load_timeout", i, N);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Starts at cycle 1 after the last accept edge; collects n outputs.
    task automatic collect(input vec_t v, input int n);
        int            cyc = 1;
        int            k = 0;
        int            guard = 0;
        logic          held = 1'b0;
        logic [EW-1:0] hd = '0;
        logic          rdy;
        while (!out_valid && cyc < 60) begin
            check("in_ready_while_busy", in_ready, 0);
            check("busy_in_sort", busy, 1);
            in_valid = 1'b1;          // must be ignored while sorting
            in_data  = '1;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency_cycles", cyc, 29);
        while (k < n && guard < 400) begin
            if (out_valid) begin
                if (held) check("hold_stable", out_data, hd);
                rdy = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    $display("out %0d: idx=%0d pm=%0d last=%0b", k,
                             out_data[EW-1:PMW], out_data[PMW-1:0], out_last);
                    check("out_data", out_data, v.exp[k]);
                    check("out_last", out_last, (k == K - 1) ? 1 : 0);
                    k++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd   = out_data;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (k < n) check("out_timeout", k, n);
        if (n == K) begin
            check("in_ready_after_last", in_ready, 1);
            check("out_valid_after_last", out_valid, 0);
        end
    endtask

    initial begin
        vec_t rv;

        // Reverse order
        for (int i = 0; i < N; i++) begin
            tbl[0].pm[i]  = 8'(70 - 10 * i);
            tbl[0].idx[i] = 3'(i);
        end
        tbl[0].exp[0] = {3'd7, 8'd0};
        tbl[0].exp[1] = {3'd6, 8'd10};
        tbl[0].exp[2] = {3'd5, 8'd20};
        tbl[0].exp[3] = {3'd4, 8'd30};
        tbl[0].bp = 1'b0;
        tbl[0].gaps = 1'b0;
        // All ties: every compare swaps, fully reversing the index order
        for (int i = 0; i < N; i++) begin
            tbl[1].pm[i]  = 8'd5;
            tbl[1].idx[i] = 3'(i);
        end
        tbl[1].exp[0] = {3'd7, 8'd5};
        tbl[1].exp[1] = {3'd6, 8'd5};
        tbl[1].exp[2] = {3'd5, 8'd5};
        tbl[1].exp[3] = {3'd4, 8'd5};
        tbl[1].bp = 1'b0;
        tbl[1].gaps = 1'b0;
        // Ascending with gaps and backpressure
        for (int i = 0; i < N; i++) begin
            tbl[2].pm[i]  = 8'(10 * i);
            tbl[2].idx[i] = 3'(i);
        end
        tbl[2].exp[0] = {3'd0, 8'd0};
        tbl[2].exp[1] = {3'd1, 8'd10};
        tbl[2].exp[2] = {3'd2, 8'd20};
        tbl[2].exp[3] = {3'd3, 8'd30};
        tbl[2].bp = 1'b1;
        tbl[2].gaps = 1'b1;
        // Max PM mixed with small values
        tbl[3].pm[0] = 8'd255; tbl[3].pm[1] = 8'd0;
        tbl[3].pm[2] = 8'd254; tbl[3].pm[3] = 8'd3;
        tbl[3].pm[4] = 8'd128; tbl[3].pm[5] = 8'd1;
        tbl[3].pm[6] = 8'd200; tbl[3].pm[7] = 8'd2;
        for (int i = 0; i < N; i++) tbl[3].idx[i] = 3'(i);
        tbl[3].exp[0] = {3'd1, 8'd0};
        tbl[3].exp[1] = {3'd5, 8'd1};
        tbl[3].exp[2] = {3'd7, 8'd2};
        tbl[3].exp[3] = {3'd3, 8'd3};
        tbl[3].bp = 1'b0;
        tbl[3].gaps = 1'b1;

        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            $display("job %0d", t);
            load_job(tbl[t]);
            collect(tbl[t], K);
        end

        // Random PMs (small range to provoke ties), backpressure and gaps
        for (int i = 0; i < N; i++) begin
            rv.pm[i]  = 8'($urandom_range(0, 15));
            rv.idx[i] = 3'(i);
            model[i]  = {rv.idx[i], rv.pm[i]};
        end
        model_sort();
        for (int i = 0; i < K; i++) rv.exp[i] = model[i];
        rv.bp = 1'b1;
        rv.gaps = 1'b1;
        $display("job random");
        load_job(rv);
        collect(rv, K);

        // Abort during SORT cycle 10, then a fresh ascending job
        $display("job abort");
        load_job(tbl[0]);
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_in_ready", in_ready, 1);
        check("clr_busy", busy, 0);
        check("clr_out_valid", out_valid, 0);
        tbl[2].bp = 1'b0;
        tbl[2].gaps = 1'b0;
        load_job(tbl[2]);
        collect(tbl[2], K);

        // Reset after two outputs, then a new job from scratch
        $display("job reset_mid_out");
        load_job(tbl[0]);
        collect(tbl[0], 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_last", out_last, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        load_job(tbl[3]);
        collect(tbl[3], K);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
